// File: rtl/voice_mix_pkg.sv
// Shared types and helpers for the stereo voice mixer.
// Optional clip-hold LED behaviour is enabled by VOICE_MIX_CLIP_HOLD_EN.
package voice_mix_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_MIX,
    S_SAT,
    S_DONE
  } state_t;

  localparam logic [1:0] PAN_BOTH  = 2'b00;
  localparam logic [1:0] PAN_LEFT  = 2'b01;
  localparam logic [1:0] PAN_RIGHT = 2'b10;
  localparam logic [1:0] PAN_MUTE  = 2'b11;

  localparam int CLIP_HOLD_FRAMES = 256;

  function automatic int acc_width(input int sw, input int nv);
    return sw + $clog2(nv) + 1;
  endfunction

  function automatic logic signed [31:0] saturate(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/voice_mix_unit_scale.sv
// Signed sample times unsigned volume, arithmetic shift back to sample width.
// Output cannot overflow: |sample| * (2^VOL_W-1) / 2^VOL_W < 2^(SAMPLE_W-1).
module voice_mix_unit_scale #(
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 4
) (
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [VOL_W-1:0]    vol,
  output logic signed [SAMPLE_W-1:0] scaled
);

  localparam int PW = SAMPLE_W + VOL_W + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  always_comb begin
    prod    = PW'(sample) * PW'($signed({1'b0, vol}));
    shifted = prod >>> VOL_W;
    scaled  = shifted[SAMPLE_W-1:0];
  end

endmodule

// File: rtl/voice_mix_unit.sv
// Time-multiplexed N-voice stereo mixer feeding the AC97 codec.
// Define VOICE_MIX_CLIP_HOLD_EN to stretch clip for a visible LED.
module voice_mix_unit
  import voice_mix_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int VOL_W      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_frame,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_ready,
  input  logic [NUM_VOICES*VOL_W-1:0]    voice_vol,
  input  logic [2*NUM_VOICES-1:0]        voice_pan,
  output logic                           generate_next,
  output logic signed [SAMPLE_W-1:0]     left_out,
  output logic signed [SAMPLE_W-1:0]     right_out,
  output logic                           new_sample,
  output logic                           clip,
  output logic                           overrun
);

  localparam int AW = acc_width(SAMPLE_W, NUM_VOICES);
  localparam int IW = $clog2(NUM_VOICES);

  state_t state;
  state_t state_nx;

  logic [NUM_VOICES-1:0]                mask;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  lat;
  logic [IW-1:0]                        idx;
  logic signed [AW-1:0]                 acc_l;
  logic signed [AW-1:0]                 acc_r;
  logic                                 clip_frame;

  logic signed [SAMPLE_W-1:0] cur_sample;
  logic        [VOL_W-1:0]    cur_vol;
  logic        [1:0]          cur_pan;
  logic signed [SAMPLE_W-1:0] scaled;
  logic                       last_idx;
  logic signed [31:0]         ext_l;
  logic signed [31:0]         ext_r;
  logic signed [31:0]         sat_l;
  logic signed [31:0]         sat_r;

  always_comb begin
    cur_sample = $signed(lat[idx]);
    cur_vol    = voice_vol[idx*VOL_W +: VOL_W];
    cur_pan    = voice_pan[idx*2 +: 2];
    last_idx   = (idx == IW'(NUM_VOICES - 1));
    ext_l      = 32'(acc_l);
    ext_r      = 32'(acc_r);
    sat_l      = saturate(ext_l, SAMPLE_W);
    sat_r      = saturate(ext_r, SAMPLE_W);
  end

  voice_mix_unit_scale #(
    .SAMPLE_W(SAMPLE_W),
    .VOL_W   (VOL_W)
  ) u_scale (
    .sample(cur_sample),
    .vol   (cur_vol),
    .scaled(scaled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (new_frame) state_nx = S_REQ;
      S_REQ:  state_nx = S_WAIT;
      S_WAIT: if (&(mask | voice_ready)) state_nx = S_MIX;
      S_MIX:  if (last_idx) state_nx = S_SAT;
      S_SAT:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask       <= '0;
      lat        <= '0;
      idx        <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      left_out   <= '0;
      right_out  <= '0;
      clip_frame <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          mask  <= '0;
          idx   <= '0;
          acc_l <= '0;
          acc_r <= '0;
        end
        S_WAIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_ready[i]) begin
              lat[i]  <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
              mask[i] <= 1'b1;
            end
          end
        end
        S_MIX: begin
          idx <= idx + 1'b1;
          if (cur_pan == PAN_BOTH || cur_pan == PAN_LEFT)
            acc_l <= acc_l + AW'(scaled);
          if (cur_pan == PAN_BOTH || cur_pan == PAN_RIGHT)
            acc_r <= acc_r + AW'(scaled);
        end
        S_SAT: begin
          left_out   <= sat_l[SAMPLE_W-1:0];
          right_out  <= sat_r[SAMPLE_W-1:0];
          clip_frame <= (sat_l != ext_l) || (sat_r != ext_r);
        end
        default: ;
      endcase
      if (new_frame && state != S_IDLE) overrun <= 1'b1;
    end
  end

`ifdef VOICE_MIX_CLIP_HOLD_EN
  logic       hold_q;
  logic [7:0] clean_cnt;

  // Hold restarts on every clipping frame; clears after a full clean run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= 1'b0;
      clean_cnt <= '0;
    end else if (state == S_DONE) begin
      if (clip_frame) begin
        hold_q    <= 1'b1;
        clean_cnt <= '0;
      end else if (hold_q) begin
        clean_cnt <= clean_cnt + 8'd1;
        if (clean_cnt == 8'(CLIP_HOLD_FRAMES - 1)) hold_q <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    generate_next = (state == S_REQ);
    new_sample    = (state == S_DONE);
`ifdef VOICE_MIX_CLIP_HOLD_EN
    clip          = hold_q | ((state == S_DONE) & clip_frame);
`else
    clip          = (state == S_DONE) & clip_frame;
`endif
  end

endmodule

// File: tb/tb_voice_mix_unit.sv
// Scoreboard bench for voice_mix_unit against a plain-arithmetic mix model.
// Default build: clip is a one-cycle pulse with new_sample.
module tb_voice_mix_unit;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int VW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             new_frame = 1'b0;
  logic [NV*SW-1:0] voice_sample = '0;
  logic [NV-1:0]    voice_ready = '0;
  logic [NV*VW-1:0] voice_vol = '0;
  logic [2*NV-1:0]  voice_pan = '0;
  logic             generate_next;
  logic [SW-1:0]    left_out;
  logic [SW-1:0]    right_out;
  logic             new_sample;
  logic             clip;
  logic             overrun;

  voice_mix_unit #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOL_W(VW)) dut (
    .clk          (clk),
    .reset        (reset),
    .new_frame    (new_frame),
    .voice_sample (voice_sample),
    .voice_ready  (voice_ready),
    .voice_vol    (voice_vol),
    .voice_pan    (voice_pan),
    .generate_next(generate_next),
    .left_out     (left_out),
    .right_out    (right_out),
    .new_sample   (new_sample),
    .clip         (clip),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
    bit c;
    int cyc;
  } exp_t;

  exp_t q[$];

  int cyc = 0;
  int gen_cnt = 0;
  int pass_m = 0, tot_m = 0;
  int pass_s = 0, tot_s = 0;

  int sv[NV];
  int vv[NV];
  int pv[NV];
  int roff[NV];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!reset && generate_next) gen_cnt <= gen_cnt + 1;

  // Monitor: every new_sample must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && new_sample) begin
      exp_t e;
      if (q.size() == 0) begin
        tot_m++;
        $display("FAIL unexpected_new_sample at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        tot_m++;
        if (int'($signed(left_out)) == e.l) pass_m++;
        else $display("FAIL left_out got %0d want %0d", $signed(left_out), e.l);
        tot_m++;
        if (int'($signed(right_out)) == e.r) pass_m++;
        else $display("FAIL right_out got %0d want %0d", $signed(right_out), e.r);
        tot_m++;
        if (clip == e.c) pass_m++;
        else $display("FAIL clip got %0b want %0b", clip, e.c);
        tot_m++;
        if (cyc == e.cyc) pass_m++;
        else $display("FAIL latency got cycle %0d want %0d", cyc, e.cyc);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    tot_s++;
    if (got == want) pass_s++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor(s*v/16) per voice, routed by pan, summed, clamped.
  task automatic model(output int l, output int r, output bit c);
    int p, s;
    l = 0;
    r = 0;
    for (int i = 0; i < NV; i++) begin
      p = sv[i] * vv[i];
      s = p / 16;
      if (p < 0 && (p % 16) != 0) s = s - 1;
      if (pv[i] == 0 || pv[i] == 1) l += s;
      if (pv[i] == 0 || pv[i] == 2) r += s;
    end
    c = 0;
    if (l > 32767) begin l = 32767; c = 1; end
    if (l < -32768) begin l = -32768; c = 1; end
    if (r > 32767) begin r = 32767; c = 1; end
    if (r < -32768) begin r = -32768; c = 1; end
  endtask

  task automatic frame(input int ovr_at, input bit do_rst);
    int l, r, mx, start, g0;
    bit c;
    exp_t e;
    mx = 0;
    for (int i = 0; i < NV; i++) begin
      if (roff[i] > mx) mx = roff[i];
      voice_sample[i*SW +: SW] = sv[i][SW-1:0];
      voice_vol[i*VW +: VW]    = vv[i][VW-1:0];
      voice_pan[i*2 +: 2]      = pv[i][1:0];
    end
    model(l, r, c);
    g0 = gen_cnt;
    start = cyc;
    if (!do_rst) begin
      e.l = l; e.r = r; e.c = c; e.cyc = start + mx + NV + 2;
      q.push_back(e);
    end
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    for (int t = 1; t <= mx; t++) begin
      for (int i = 0; i < NV; i++) voice_ready[i] = (roff[i] == t);
      new_frame = (t == ovr_at);
      step();
    end
    voice_ready = '0;
    new_frame = 1'b0;
    if (do_rst) begin
      step();
      reset = 1'b1;
      #1;
      chk("rst_mid_left", int'(left_out), 0);
      chk("rst_mid_right", int'(right_out), 0);
      chk("rst_mid_overrun", int'(overrun), 0);
      chk("rst_mid_new_sample", int'(new_sample), 0);
      step();
      reset = 1'b0;
      repeat (NV + 6) step();
    end else begin
      repeat (NV + 6) step();
      chk("gen_next_once", gen_cnt - g0, 1);
    end
  endtask

  task automatic set_all(input int s, input int v, input int p, input int ro);
    for (int i = 0; i < NV; i++) begin
      sv[i] = s; vv[i] = v; pv[i] = p; roff[i] = ro;
    end
  endtask

  initial begin
    #1;
    chk("rst_left", int'(left_out), 0);
    chk("rst_right", int'(right_out), 0);
    chk("rst_gen", int'(generate_next), 0);
    chk("rst_new_sample", int'(new_sample), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_overrun", int'(overrun), 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    set_all(1000, 15, 0, 2);
    frame(0, 0);

    set_all(30000, 15, 3, 3);
    pv[0] = 1; pv[1] = 1;
    frame(0, 0);

    set_all(-32768, 15, 0, 4);
    frame(0, 0);

    set_all(1000, 15, 0, 0);
    sv[1] = -2000; vv[2] = 7; pv[3] = 2;
    roff[2] = 3; roff[0] = 5; roff[3] = 9; roff[1] = 12;
    frame(0, 0);

    chk("overrun_clear", int'(overrun), 0);
    set_all(-1234, 9, 0, 6);
    pv[1] = 1;
    frame(3, 0);
    chk("overrun_set", int'(overrun), 1);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < NV; i++) begin
        sv[i]   = int'($urandom_range(65535)) - 32768;
        vv[i]   = int'($urandom_range(15));
        pv[i]   = int'($urandom_range(3));
        roff[i] = int'($urandom_range(8, 2));
      end
      frame(0, 0);
    end
    chk("overrun_sticky", int'(overrun), 1);

    set_all(5000, 8, 0, 2);
    frame(0, 1);

    set_all(2000, 12, 0, 2);
    pv[2] = 2;
    frame(0, 0);

    for (int t = 0; t < 50 && q.size() != 0; t++) step();
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", pass_m + pass_s, tot_m + tot_s);
    $finish;
  end

endmodule

// File: doc/voice_mix_unit.md
Name: voice_mix_unit

Overview:
- Time-multiplexed N-voice stereo mixer between the note/voice generators and the AC97 codec.
- On each codec `new_frame`, it requests one sample from every voice and waits until all voices report ready.
- It then applies per-voice volume and pan, accumulates serially, saturates, and presents held left/right PCM samples with a `new_sample` strobe.
- It replaces the single mono `codec_sample` path, so the codec gets independent left/right data.

Parameters:
- NUM_VOICES, 4, number of voice inputs (2..8).
- SAMPLE_W, 16, signed sample width, in and out.
- VOL_W, 4, unsigned per-voice volume width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- new_frame  input  1  1-cycle pulse from codec: next sample wanted.
- voice_sample  input  NUM_VOICES*SAMPLE_W  packed signed samples; voice i at [i*SAMPLE_W +: SAMPLE_W].
- voice_ready  input  NUM_VOICES  per-voice pulse: sample i valid this cycle.
- voice_vol  input  NUM_VOICES*VOL_W  per-voice gain, unsigned.
- voice_pan  input  2*NUM_VOICES  per-voice pan: 00 both, 01 left only, 10 right only, 11 mute.
- generate_next  output  1  1-cycle pulse to all voices: produce next sample.
- left_out  output  SAMPLE_W  held signed left PCM.
- right_out  output  SAMPLE_W  held signed right PCM.
- new_sample  output  1  1-cycle pulse: left_out/right_out updated.
- clip  output  1  saturation indicator.
- overrun  output  1  sticky: new_frame arrived while busy.

Behaviour:
- Reset (async, active-high):
  - Outputs: left_out=0, right_out=0, generate_next=0, new_sample=0, clip=0, overrun=0.
  - Internal: FSM=IDLE; ready mask, sample latches and accumulators cleared.
- FSM states: IDLE, REQ, WAIT, MIX, SAT, DONE.
- IDLE: on new_frame go to REQ.
- REQ: generate_next=1 for exactly one cycle; clear ready mask; go to WAIT.
- WAIT:
  - For each i with voice_ready[i]=1, latch voice_sample slice i and set mask bit i.
  - Later pulses for an already-set bit re-latch that voice's sample (last wins).
  - When the mask is all ones (including bits set this cycle), go to MIX next cycle.
- MIX: one voice per cycle, index 0..NUM_VOICES-1.
  - scaled = (sample * vol) >>> VOL_W. Signed product is SAMPLE_W+VOL_W+1 bits; the shift is arithmetic, truncating toward -inf. vol=0 gives 0.
  - Add scaled to the left and/or right accumulator according to pan.
  - Accumulator width is SAMPLE_W+clog2(NUM_VOICES)+1, so the accumulators never overflow.
  - After the last index, go to SAT.
- SAT: clamp each accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; flag clip if either channel clamped.
- DONE:
  - Register left_out/right_out; new_sample=1 for one cycle; return to IDLE.
  - Outputs hold until the next DONE.
- Latency:
  - new_frame (cycle 0) to generate_next = cycle 1.
  - Last ready pulse (cycle R) to new_sample = cycle R+NUM_VOICES+2.
- Boundary conditions:
  - new_frame in any state other than IDLE is ignored and sets overrun. overrun clears only on reset.
  - new_frame in the same cycle as the DONE→IDLE transition is ignored and counts as overrun.
  - voice_ready outside WAIT is ignored.
  - vol/pan are sampled during each voice's MIX cycle. Changes mid-frame affect only voices not yet mixed.
  - Reset mid-frame aborts with no new_sample, and outputs go to 0.

Optional Feature:
- Macro: VOICE_MIX_CLIP_HOLD_EN.
- Defined:
  - clip is set at DONE of any frame that saturated.
  - clip stays high until 256 consecutive non-clipping frames complete; an 8-bit frame counter restarts on each clipping frame. Intended for a visible LED.
- Undefined: clip is a 1-cycle pulse coincident with new_sample, high only for a frame that saturated.

Decomposition:
- Shared package voice_mix_pkg:
  - FSM state enum.
  - Pan encoding constants PAN_BOTH/PAN_LEFT/PAN_RIGHT/PAN_MUTE.
  - Accumulator-width function.
  - Saturate function.
  - CLIP_HOLD_FRAMES=256.
- One natural sub-module: voice_scale, the combinational signed sample×volume with arithmetic shift, shared by the MIX datapath.

Test Plan:
- NUM_VOICES=4, all vol=15, pan=00, samples 1000 each:
  - new_frame, all ready at R → left_out=right_out=3748 (4×937), new_sample at R+6, clip=0.
- Voice0=+30000 vol 15 pan 01; voice1=+30000 vol 15 pan 01; others mute:
  - left_out=32767, right_out=0, clip asserted.
  - With VOICE_MIX_CLIP_HOLD_EN, clip stays high for 256 following clean frames.
- Negative saturation: all four voices -32768, vol 15, pan 00 → left_out=right_out=-32768, clip=1.
- Staggered ready pulses (voice 2 at +3, 0 at +5, 3 at +9, 1 at +12) → single new_sample at +12+6. generate_next pulses exactly once.
- new_frame re-asserted during WAIT → ignored, overrun=1 and sticky; frame completes normally.
- reset pulsed during MIX → all outputs 0 asynchronously, no new_sample; next new_frame mixes correctly.
